// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the valid/ready memory bus master.
// States, command/response bundles and default geometry.
package mem_bus_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 64;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic                 wr;
      logic [DEF_AW-1:0]    addr;
      logic [DEF_WIDTH-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic                 wr;
      logic [DEF_WIDTH-1:0] rdata;
      logic                 err;
   } rsp_t;

endpackage

// File: rtl/mem_bus_wdog.sv
// WAIT-state watchdog: cleared on entry to WAIT, counts stalled cycles,
// flags expiry on the LIMIT-th stalled cycle.
module mem_bus_wdog #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   assign expire = en && (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && !expire) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_bus_master.sv
// One-command-at-a-time initiator for the valid/ready memory.
// Define MEM_BUS_MASTER_TIMEOUT_EN to enable the WAIT-state watchdog.
module mem_bus_master
   import mem_bus_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [WIDTH-1:0]      cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_wr,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_valid,
   output logic                  mem_wt_rd,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic [WIDTH-1:0]      mem_rdata,
   input  logic                  mem_ready,
   output logic                  busy,
   output logic [15:0]           txn_count
);

   state_t state;
   logic   expire;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
   mem_bus_wdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == ISSUE),
      .en     ((state == WAIT) && !mem_ready),
      .expire (expire)
   );

   // Only a WAIT exit can change the error flag; ready beats expiry.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_err <= 1'b0;
      end else if (state == WAIT) begin
         rsp_err <= expire;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign expire  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   assign cmd_ready = (state == IDLE) && !rst;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_valid <= 1'b0;
         mem_wt_rd <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_wr    <= 1'b0;
         rsp_rdata <= '0;
         txn_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  mem_wt_rd <= cmd_wr;
                  mem_addr  <= cmd_addr;
                  mem_wdata <= cmd_wdata;
                  mem_valid <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_valid <= 1'b0;
               state     <= WAIT;
            end
            WAIT: begin
               if (mem_ready) begin
                  rsp_valid <= 1'b1;
                  rsp_wr    <= mem_wt_rd;
                  rsp_rdata <= mem_wt_rd ? '0 : mem_rdata;
                  state     <= RESP;
               end else if (expire) begin
                  rsp_valid <= 1'b1;
                  rsp_wr    <= mem_wt_rd;
                  rsp_rdata <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  txn_count <= txn_count + 16'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator for the team's single-port valid/ready memory (wt_rd, addr, wdata, rdata).
- Accepts one command at a time from an upstream agent and drives the memory request with a one-cycle mem_valid pulse.
- Waits for mem_ready, then returns a write ack or read data on a response channel.
- Sits between test or processor logic and the memory instance.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 64, memory words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT_CYCLES, 15, WAIT-state cycles before timeout; used only with the macro.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  master can accept a command.
- cmd_wr  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  command address.
- cmd_wdata  in  WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  upstream accepts response.
- rsp_wr  out  1  response belongs to a write.
- rsp_rdata  out  WIDTH  read data; 0 for writes.
- rsp_err  out  1  timeout error; tied 0 without the macro.
- mem_valid  out  1  memory request strobe.
- mem_wt_rd  out  1  memory write/read select.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completion; high the cycle after mem_valid is sampled.
- busy  out  1  state != IDLE.
- txn_count  out  16  completed transactions.

Behaviour:
- Reset:
  - clk rising edge with rst=1 → state IDLE.
  - mem_valid, mem_wt_rd, mem_addr, mem_wdata, rsp_valid, rsp_wr, rsp_rdata, rsp_err, txn_count all 0.
  - cmd_ready = (state==IDLE) && !rst, so it is 0 during reset.
- All mem_* and rsp_* outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready: latch cmd_wr/cmd_addr/cmd_wdata into mem_wt_rd/mem_addr/mem_wdata; go to ISSUE.
- ISSUE:
  - mem_valid=1 for exactly one cycle; go to WAIT.
- WAIT:
  - mem_valid=0.
  - On mem_ready=1: rsp_rdata = mem_wt_rd ? 0 : mem_rdata; rsp_wr = mem_wt_rd; rsp_err = 0; go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On rsp_ready: rsp_valid=0, txn_count+1 (wraps 0xFFFF→0), go to IDLE.
- Latency: command accepted at edge N → mem_valid high cycle N+1 → mem_ready cycle N+2 → rsp_valid cycle N+3. With rsp_ready high, cmd_ready returns cycle N+4, giving 1 transaction per 4 cycles.
- mem_addr, mem_wdata and mem_wt_rd hold their last values outside ISSUE.
- cmd_valid is ignored outside IDLE; a command is never dropped, since upstream holds it until cmd_ready.
- mem_ready outside WAIT is ignored and has no state effect.
- Address range is 0..DEPTH-1 by width; no range check.
- Reset mid-transaction: the in-flight command is discarded, no response is produced, and all outputs go to reset values at that edge.

Optional Feature:
- Macro MEM_BUS_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and counts each WAIT cycle with mem_ready=0.
  - If the count reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1, rsp_rdata=0.
  - mem_ready in the same cycle as the terminal count wins: normal response, rsp_err=0.
  - Timed-out transactions still increment txn_count.
- Not defined:
  - No counter logic; WAIT lasts indefinitely.
  - rsp_err constant 0.

Decomposition:
- Package mem_bus_pkg holds:
  - default WIDTH/DEPTH constants;
  - state enum typedef (IDLE, ISSUE, WAIT, RESP);
  - command struct typedef {wr, addr, wdata};
  - response struct typedef {wr, rdata, err}.
- One sub-module, mem_bus_wdog: clear/enable/expire timeout counter, instantiated only under MEM_BUS_MASTER_TIMEOUT_EN.

Test Plan:
1. Reset: assert rst 3 cycles mid-WAIT → all outputs 0, cmd_ready=0 during rst and 1 the cycle after release; no rsp_valid.
2. Write then read: write addr 5 data 0xBEEF, then read addr 5 → write ack rsp_wr=1, rsp_rdata=0; read rsp_rdata=0xBEEF, rsp_err=0; mem_valid exactly one cycle per transaction; txn_count=2.
3. Latency: command accepted at edge N with rsp_ready=1 → mem_valid only in cycle N+1, rsp_valid in cycle N+3, cmd_ready high again cycle N+4.
4. Backpressure: rsp_ready low 5 cycles after a read of addr 63 = 0xFFFF → rsp_valid/rsp_rdata stable at 0xFFFF, cmd_ready=0, no extra mem_valid, cmd_valid held upstream not accepted.
5. Boundaries: write/read addr 0 with 0x0000 and addr 63 with 0xFFFF → exact readback; preload txn_count path to 0xFFFF, one more transaction → 0.
6. Timeout (macro defined, mem_ready tied 0): read addr 10 → rsp_valid with rsp_err=1, rsp_rdata=0 after 15 WAIT cycles. Then mem_ready asserted on the 15th WAIT cycle → rsp_err=0.
